// File: rtl/patgen_pwm.sv
// Multi-channel thermometer-pattern PWM generator with double-buffered per-channel selects.
// Optional feature macro: PATGEN_POLARITY_EN adds the POL input for per-channel output inversion.
module patgen_pwm #(
    parameter int CNT_W = 3,
    parameter int NCH   = 4,
    parameter int SEL_W = 3,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK,
    input  logic             CLEAR_N,
    input  logic             EN,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [CH_W-1:0]  WR_CH,
    input  logic [SEL_W-1:0] WR_SEL,
`ifdef PATGEN_POLARITY_EN
    input  logic [NCH-1:0]   POL,
`endif
    output logic [CNT_W-1:0] PHASE,
    output logic             PERIOD_START,
    output logic [NCH-1:0]   O
);

    localparam logic [CNT_W-1:0] PH_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] phase_q, phase_d;
    logic             ps_q, ps_d;
    logic [NCH-1:0]   o_q, o_d;
    logic [SEL_W-1:0] active_q   [NCH];
    logic [SEL_W-1:0] active_d   [NCH];
    logic [SEL_W-1:0] pend_sel_q [NCH];
    logic [SEL_W-1:0] pend_sel_d [NCH];
    logic [NCH-1:0]   pend_vld_q, pend_vld_d;
    logic [NCH-1:0]   wr_hit;
    logic             wr_ready;
    logic             wrap;
    logic [NCH-1:0]   pol;

`ifdef PATGEN_POLARITY_EN
    assign pol = POL;
`else
    assign pol = '0;
`endif

    // Entry k sets its low (k+1)*2^(CNT_W-SEL_W) bits, so bit p is set iff p is below that length.
    function automatic logic [CNT_W:0] ones_len(input logic [SEL_W-1:0] k);
        return ((CNT_W+1)'(k) + (CNT_W+1)'(1)) << (CNT_W - SEL_W);
    endfunction

    // Channel numbers past NCH-1 match no channel: ready stays high and the write is dropped.
    always_comb begin
        wr_ready = 1'b1;
        wr_hit   = '0;
        for (int c = 0; c < NCH; c++) begin
            if (WR_CH == CH_W'(c)) begin
                wr_ready  = ~pend_vld_q[c];
                wr_hit[c] = WR_VALID & ~pend_vld_q[c];
            end
        end
    end

    assign wrap = EN && (phase_q == PH_MAX);

    always_comb begin
        phase_d    = phase_q;
        ps_d       = 1'b0;
        o_d        = o_q;
        active_d   = active_q;
        pend_sel_d = pend_sel_q;
        pend_vld_d = pend_vld_q;

        if (EN) begin
            phase_d = wrap ? '0 : phase_q + 1'b1;
            ps_d    = wrap;
            for (int c = 0; c < NCH; c++) begin
                if (wrap && pend_vld_q[c]) begin
                    active_d[c]   = pend_sel_q[c];
                    pend_vld_d[c] = 1'b0;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                o_d[c] = ({1'b0, phase_d} < ones_len(active_d[c])) ^ pol[c];
            end
        end

        // A write only hits a channel with nothing pending, so it never races the transfer above.
        for (int c = 0; c < NCH; c++) begin
            if (wr_hit[c]) begin
                pend_sel_d[c] = WR_SEL;
                pend_vld_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            phase_q    <= PH_MAX;
            ps_q       <= 1'b0;
            o_q        <= '0;
            active_q   <= '{default: '0};
            pend_sel_q <= '{default: '0};
            pend_vld_q <= '0;
        end else begin
            phase_q    <= phase_d;
            ps_q       <= ps_d;
            o_q        <= o_d;
            active_q   <= active_d;
            pend_sel_q <= pend_sel_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign WR_READY     = wr_ready;
    assign PHASE        = phase_q;
    assign PERIOD_START = ps_q;
    assign O            = o_q;

endmodule

// File: tb/tb_patgen_pwm.sv
// Randomized self-checking bench for patgen_pwm against a per-cycle behavioural model.
module tb_patgen_pwm;
    localparam int CNT_W = 3;
    localparam int NCH   = 4;
    localparam int SEL_W = 3;
    localparam int CH_W  = 2;
    localparam int PER   = 1 << CNT_W;

    logic             CLK = 1'b0;
    logic             CLEAR_N;
    logic             EN;
    logic             WR_VALID;
    logic             WR_READY;
    logic [CH_W-1:0]  WR_CH;
    logic [SEL_W-1:0] WR_SEL;
    logic [CNT_W-1:0] PHASE;
    logic             PERIOD_START;
    logic [NCH-1:0]   O;
    logic [NCH-1:0]   pol_v = '0;

    always #5 CLK = ~CLK;

    patgen_pwm #(.CNT_W(CNT_W), .NCH(NCH), .SEL_W(SEL_W)) dut (
        .CLK(CLK),
        .CLEAR_N(CLEAR_N),
        .EN(EN),
        .WR_VALID(WR_VALID),
        .WR_READY(WR_READY),
        .WR_CH(WR_CH),
        .WR_SEL(WR_SEL),
`ifdef PATGEN_POLARITY_EN
        .POL(pol_v),
`endif
        .PHASE(PHASE),
        .PERIOD_START(PERIOD_START),
        .O(O)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: channel state as plain integers, pattern bit from the thermometer length.
    int             m_phase;
    int             m_active [NCH];
    int             m_psel   [NCH];
    bit             m_pvld   [NCH];
    bit             m_ps;
    logic [NCH-1:0] m_o;

    function automatic int entry_len(input int k);
        return ((k + 1) * PER) / (1 << SEL_W);
    endfunction

    function automatic bit m_ready(input int ch);
        return (ch >= NCH) ? 1'b1 : !m_pvld[ch];
    endfunction

    task automatic m_reset();
        m_phase = PER - 1;
        for (int c = 0; c < NCH; c++) begin
            m_active[c] = 0;
            m_psel[c]   = 0;
            m_pvld[c]   = 0;
        end
        m_ps = 0;
        m_o  = '0;
    endtask

    task automatic m_edge(input bit en, input bit wv, input int ch, input int sel,
                          input logic [NCH-1:0] pol);
        bit acc;
        bit bnd;
        acc = wv && (ch < NCH) && !m_pvld[ch];
        if (en) begin
            bnd     = (m_phase == PER - 1);
            m_phase = bnd ? 0 : m_phase + 1;
            m_ps    = bnd;
            if (bnd) begin
                for (int c = 0; c < NCH; c++) begin
                    if (m_pvld[c]) begin
                        m_active[c] = m_psel[c];
                        m_pvld[c]   = 0;
                    end
                end
            end
            for (int c = 0; c < NCH; c++)
                m_o[c] = (m_phase < entry_len(m_active[c])) ^ pol[c];
        end else begin
            m_ps = 0;
        end
        if (acc) begin
            m_psel[ch] = sel;
            m_pvld[ch] = 1;
        end
    endtask

    task automatic step(input bit en, input bit wv, input int ch, input int sel);
        @(negedge CLK);
        EN       = en;
        WR_VALID = wv;
        WR_CH    = ch[CH_W-1:0];
        WR_SEL   = sel[SEL_W-1:0];
        #1;
        chk("wr_ready", {31'd0, WR_READY}, {31'd0, m_ready(ch)});
        @(posedge CLK);
        m_edge(en, wv, ch, sel, pol_v);
        #1;
        chk("phase", {29'd0, PHASE}, m_phase);
        chk("period_start", {31'd0, PERIOD_START}, {31'd0, m_ps});
        chk("o", {28'd0, O}, {28'd0, m_o});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
    endtask

    task automatic run_to_phase(input int p);
        for (int i = 0; i < PER && m_phase != p; i++) step(1'b1, 1'b0, 0, 0);
        chk("run_to_phase", m_phase, p);
    endtask

    // Hold the request until the model says it is taken at an edge; bounded by a few periods.
    task automatic write_sel(input int ch, input int sel);
        bit done;
        done = 0;
        for (int i = 0; i < 3 * PER && !done; i++) begin
            done = m_ready(ch);
            step(1'b1, 1'b1, ch, sel);
        end
        chk("write_accept", {31'd0, done}, 32'd1);
    endtask

    initial begin
        CLEAR_N  = 1'b0;
        EN       = 1'b0;
        WR_VALID = 1'b0;
        WR_CH    = '0;
        WR_SEL   = '0;
        m_reset();
        #12;
        chk("rst_phase", {29'd0, PHASE}, PER - 1);
        chk("rst_o", {28'd0, O}, 32'd0);
        chk("rst_ps", {31'd0, PERIOD_START}, 32'd0);
        chk("rst_ready", {31'd0, WR_READY}, 32'd1);
        @(negedge CLK);
        CLEAR_N = 1'b1;

        // Free run: first edge is a boundary with every channel on entry 0.
        step(1'b1, 1'b0, 0, 0);
        chk("first_phase", {29'd0, PHASE}, 32'd0);
        chk("first_ps", {31'd0, PERIOD_START}, 32'd1);
        chk("first_o", {28'd0, O}, 32'hF);
        idle(7);
        chk("p7_o", {28'd0, O}, 32'h0);

        // ch2 = 3 written mid-period, visible from the next period.
        run_to_phase(4);
        write_sel(2, 3);
        idle(2 * PER);

        // Back-to-back writes to ch1: the second stalls until the boundary.
        write_sel(1, 5);
        write_sel(1, 2);
        idle(2 * PER);

        // Write accepted on the boundary edge itself.
        run_to_phase(PER - 1);
        step(1'b1, 1'b1, 0, 7);
        idle(2 * PER);
        chk("ch0_full", {31'd0, O[0]}, 32'd1);

        // EN low mid-period, with a write still accepted while frozen.
        run_to_phase(3);
        step(1'b0, 1'b1, 3, 6);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0);
        chk("frozen_phase", {29'd0, PHASE}, 32'd3);
        idle(2 * PER);

        // Randomized traffic, including channel writes during EN low.
        for (int i = 0; i < 1500; i++) begin
`ifdef PATGEN_POLARITY_EN
            pol_v = NCH'($urandom);
`endif
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, (1 << SEL_W) - 1)));
        end

        // Asynchronous reset mid-period with a pending select.
        pol_v = '0;
        run_to_phase(3);
        write_sel(3, 7);
        @(negedge CLK);
        EN       = 1'b0;
        WR_VALID = 1'b0;
        WR_CH    = 2'd3;
        #2;
        CLEAR_N = 1'b0;
        #1;
        m_reset();
        chk("async_phase", {29'd0, PHASE}, PER - 1);
        chk("async_o", {28'd0, O}, 32'd0);
        chk("async_ready", {31'd0, WR_READY}, 32'd1);
        @(negedge CLK);
        CLEAR_N = 1'b1;
        idle(2 * PER);
        chk("after_rst_o", {28'd0, O}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
